// File: rtl/inst_sram_resp.sv
// inst_sram_resp: synchronous instruction memory answering the IF stage.
// Translates kseg0/kseg1 virtual addresses to physical, answers every
// accepted request exactly one cycle later, and holds its response while
// idle. A backdoor preload port fills the array for boot images.
module inst_sram_resp #(
  parameter int          ADDR_W     = 16,
  parameter logic [31:0] BASE_PADDR = 32'h1fc0_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_sram_en,
  input  logic [3:0]        inst_sram_wen,
  input  logic [31:0]       inst_sram_addr,
  input  logic [31:0]       inst_sram_wdata,
  output logic [31:0]       inst_sram_rdata,
  output logic              resp_err,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Capacity in bytes, held one bit wider than needed so that the range
  // compare stays correct even when the array spans 4 GB.
  localparam logic [33:0] CAP_BYTES = 34'(4) << ADDR_W;

  logic [31:0]       mem [DEPTH];

  logic [31:0]       paddr;
  logic [31:0]       off;
  logic              in_range;
  logic [ADDR_W-1:0] index;
  logic              accept;
  logic              hit;
  logic              port_wr;
  logic              ld_collide;

  // Address translation and range check. Offsets below the base underflow
  // to large values and fall out of range naturally, so no wrap is possible.
  always_comb begin
    paddr = inst_sram_addr;
    if (inst_sram_addr[31:30] == 2'b10) begin
      paddr = {3'b000, inst_sram_addr[28:0]};
    end
    off      = paddr - BASE_PADDR;
    in_range = ({2'b00, off} < CAP_BYTES);
    index    = off[ADDR_W+1:2];
  end

  // Request qualification. Reset suppresses the port entirely; the preload
  // port takes the whole word when it targets the same index as a port write.
  always_comb begin
    accept     = inst_sram_en && !reset;
    hit        = accept && in_range;
    port_wr    = hit && (inst_sram_wen != 4'b0000);
    ld_collide = ld_en && (ld_addr == index);
  end

  // Array update: byte-lane port writes plus the full-word preload port.
  always_ff @(posedge clk) begin
    if (port_wr && !ld_collide) begin
      for (int i = 0; i < 4; i++) begin
        if (inst_sram_wen[i]) begin
          mem[index][8*i +: 8] <= inst_sram_wdata[8*i +: 8];
        end
      end
    end
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end
  end

  // Registered response. The read samples the array before this edge's
  // writes land, giving read-first behaviour; idle cycles hold the response.
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_sram_rdata <= 32'h0;
      resp_err        <= 1'b0;
    end else if (accept) begin
      if (in_range) begin
        inst_sram_rdata <= mem[index];
        resp_err        <= 1'b0;
      end else begin
        inst_sram_rdata <= 32'h0;
        resp_err        <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_sram_resp.sv
// tb_inst_sram_resp: table-driven and hand-written checks of inst_sram_resp,
// with expected responses queued at drive time and popped one cycle later.
module tb_inst_sram_resp;

  localparam int ADDR_W = 16;

  logic              clk;
  logic              reset;
  logic              inst_sram_en;
  logic [3:0]        inst_sram_wen;
  logic [31:0]       inst_sram_addr;
  logic [31:0]       inst_sram_wdata;
  logic [31:0]       inst_sram_rdata;
  logic              resp_err;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_data;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  typedef struct {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  resp_t sb[$];
  vec_t  vecs[17];
  int    test_count;
  int    fail_count;

  inst_sram_resp #(
    .ADDR_W    (ADDR_W),
    .BASE_PADDR(32'h1fc0_0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_wen  (inst_sram_wen),
    .inst_sram_addr (inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata),
    .resp_err       (resp_err),
    .ld_en          (ld_en),
    .ld_addr        (ld_addr),
    .ld_data        (ld_data)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Pops the oldest expected response and compares it with the DUT outputs.
  task automatic checkOutput(input string name);
    resp_t e;
    test_count++;
    if (sb.size() == 0) begin
      fail_count++;
      $display("[TB] FAIL %s: got rdata=%h err=%b, expected a queued response (queue empty)",
               name, inst_sram_rdata, resp_err);
      return;
    end
    e = sb.pop_front();
    if (inst_sram_rdata !== e.rdata || resp_err !== e.err) begin
      fail_count++;
      $display("[TB] FAIL %s: got rdata=%h err=%b, expected rdata=%h err=%b",
               name, inst_sram_rdata, resp_err, e.rdata, e.err);
    end
  endtask

  // Drives one request for a single cycle, queues its expected response and
  // checks it just after the edge that produces it.
  task automatic applyStimulus(input logic rst, input logic [3:0] wen,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_rdata, input logic exp_err,
                               input string name);
    reset           = rst;
    inst_sram_en    = 1'b1;
    inst_sram_wen   = wen;
    inst_sram_addr  = addr;
    inst_sram_wdata = wdata;
    sb.push_back('{rdata: exp_rdata, err: exp_err});
    @(posedge clk);
    #1;
    inst_sram_en  = 1'b0;
    inst_sram_wen = 4'b0000;
    reset         = 1'b0;
    checkOutput(name);
  endtask

  // Idle cycles: the response must hold the given value every cycle.
  task automatic idleCheck(input int n, input logic [31:0] exp_rdata,
                           input logic exp_err, input string name);
    inst_sram_en = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      sb.push_back('{rdata: exp_rdata, err: exp_err});
      checkOutput($sformatf("%s[%0d]", name, i));
    end
  endtask

  // Backdoor preload of one word.
  task automatic preload(input logic [ADDR_W-1:0] idx, input logic [31:0] data);
    ld_en   = 1'b1;
    ld_addr = idx;
    ld_data = data;
    @(posedge clk);
    #1;
    ld_en = 1'b0;
  endtask

  // Main sequence.
  initial begin
    test_count      = 0;
    fail_count      = 0;
    reset           = 1'b1;
    inst_sram_en    = 1'b0;
    inst_sram_wen   = 4'b0000;
    inst_sram_addr  = 32'h0;
    inst_sram_wdata = 32'h0;
    ld_en           = 1'b0;
    ld_addr         = '0;
    ld_data         = 32'h0;

    vecs[0]  = '{4'b0000, 32'hbfc0_0000, 32'h0,         32'h2408_0001, 1'b0};
    vecs[1]  = '{4'b0000, 32'hbfc0_0004, 32'h0,         32'h2409_0002, 1'b0};
    vecs[2]  = '{4'b0000, 32'h9fc0_0004, 32'h0,         32'h2409_0002, 1'b0};
    vecs[3]  = '{4'b0101, 32'hbfc0_0008, 32'h1122_3344, 32'hAABB_CCDD, 1'b0};
    vecs[4]  = '{4'b0000, 32'hbfc0_0008, 32'h0,         32'hAA22_CC44, 1'b0};
    vecs[5]  = '{4'b0000, 32'hbfc4_0000, 32'h0,         32'h0,         1'b1};
    vecs[6]  = '{4'b0000, 32'hbfc3_fffc, 32'h0,         32'hCAFE_F00D, 1'b0};
    vecs[7]  = '{4'b0000, 32'hbfbf_fffc, 32'h0,         32'h0,         1'b1};
    vecs[8]  = '{4'b0000, 32'hbfc0_0000, 32'h0,         32'h2408_0001, 1'b0};
    vecs[9]  = '{4'b1111, 32'hbfbf_fffc, 32'hDEAD_BEEF, 32'h0,         1'b1};
    vecs[10] = '{4'b1111, 32'hbfc4_0000, 32'h1234_5678, 32'h0,         1'b1};
    vecs[11] = '{4'b0000, 32'hbfc0_0000, 32'h0,         32'h2408_0001, 1'b0};
    vecs[12] = '{4'b0000, 32'hbfc3_fffc, 32'h0,         32'hCAFE_F00D, 1'b0};
    vecs[13] = '{4'b1000, 32'hbfc0_0004, 32'h7700_0000, 32'h2409_0002, 1'b0};
    vecs[14] = '{4'b0000, 32'h1fc0_0004, 32'h0,         32'h7709_0002, 1'b0};
    vecs[15] = '{4'b0000, 32'h0000_0000, 32'h0,         32'h0,         1'b1};
    vecs[16] = '{4'b0000, 32'hdfc0_0000, 32'h0,         32'h0,         1'b1};

    // Preload runs while reset is held; the preload port stays live in reset.
    preload(16'h0000, 32'h2408_0001);
    preload(16'h0001, 32'h2409_0002);
    preload(16'h0002, 32'hAABB_CCDD);
    preload(16'h0003, 32'h0102_0304);
    preload(16'hffff, 32'hCAFE_F00D);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    sb.push_back('{rdata: 32'h0, err: 1'b0});
    checkOutput("reset_state");
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b0, vecs[i].wen, vecs[i].addr, vecs[i].wdata,
                    vecs[i].exp_rdata, vecs[i].exp_err, $sformatf("vec%0d", i));
    end

    // Error response holds while idle.
    idleCheck(2, 32'h0, 1'b1, "hold_err");

    // Data holds for five idle cycles after a read.
    applyStimulus(1'b0, 4'b0000, 32'hbfc0_0000, 32'h0, 32'h2408_0001, 1'b0, "hold_read");
    idleCheck(5, 32'h2408_0001, 1'b0, "hold_data");

    // Preload and port write hit the same index: preload wins whole word.
    ld_en = 1'b1; ld_addr = 16'h0003; ld_data = 32'h5555_5555;
    applyStimulus(1'b0, 4'b1111, 32'hbfc0_000c, 32'h9999_9999, 32'h0102_0304, 1'b0, "ld_vs_write");
    ld_en = 1'b0;
    applyStimulus(1'b0, 4'b0000, 32'hbfc0_000c, 32'h0, 32'h5555_5555, 1'b0, "ld_vs_write_after");

    // Preload and port read hit the same index: read sees the old word.
    ld_en = 1'b1; ld_addr = 16'h0003; ld_data = 32'h6666_6666;
    applyStimulus(1'b0, 4'b0000, 32'hbfc0_000c, 32'h0, 32'h5555_5555, 1'b0, "ld_vs_read");
    ld_en = 1'b0;
    applyStimulus(1'b0, 4'b0000, 32'hbfc0_000c, 32'h0, 32'h6666_6666, 1'b0, "ld_vs_read_after");

    // Reset mid-stream: error state cleared, requests under reset dropped.
    applyStimulus(1'b0, 4'b0000, 32'hbfc0_0000, 32'h0, 32'h2408_0001, 1'b0, "stream_read");
    applyStimulus(1'b0, 4'b0000, 32'hbfc4_0000, 32'h0, 32'h0,         1'b1, "stream_oor");
    applyStimulus(1'b1, 4'b0000, 32'hbfc0_0004, 32'h0, 32'h0,         1'b0, "reset_read");
    applyStimulus(1'b1, 4'b1111, 32'hbfc0_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, "reset_write");
    applyStimulus(1'b0, 4'b0000, 32'hbfc0_0000, 32'h0, 32'h2408_0001, 1'b0, "array_kept");
    applyStimulus(1'b0, 4'b0000, 32'hbfc0_0006, 32'h0, 32'h7709_0002, 1'b0, "unaligned");

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
